// File: rtl/rf_wport_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// DSIZE/ASIZE/NREG must track the register file that this block feeds.
package rf_wport_arbiter_pkg;

  localparam int DSIZE = 16;
  localparam int ASIZE = 4;
  localparam int NREG  = 16;

  // One buffered long-latency result.
  typedef struct packed {
    logic [ASIZE-1:0] waddr;
    logic [DSIZE-1:0] wdata;
  } wb_entry_t;

  // Which source owns the write port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_FIFO = 2'd2
  } gnt_t;

  // Register address to a one-hot scoreboard mask.
  function automatic logic [NREG-1:0] addr_onehot(input logic [ASIZE-1:0] a);
    logic [NREG-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Two-entry FIFO holding long-latency results until the write port is free.
// Pointers and occupancy are reset; the payload storage is not.
module rf_wb_fifo
  import rf_wport_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  wb_entry_t  mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign head    = mem[rd_ptr];
  // A pop in the same cycle frees a slot, so a push into a full FIFO is legal then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Occupancy and pointer update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload write; no reset needed because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the register file's single write port between the pipeline WB stage
// and a buffered long-latency unit. Keeps a per-register busy scoreboard for
// decode hazards and forces a one-cycle pipeline freeze when a buffered result
// has waited too long.
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int MAXWAIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_wen,
  input  logic [ASIZE-1:0] p_waddr,
  input  logic [DSIZE-1:0] p_wdata,
  input  logic             l_valid,
  input  logic [ASIZE-1:0] l_waddr,
  input  logic [DSIZE-1:0] l_wdata,
  output logic             l_ready,
  input  logic             iss_valid,
  input  logic [ASIZE-1:0] iss_waddr,
  input  logic [ASIZE-1:0] rs_addr,
  input  logic [ASIZE-1:0] rt_addr,
  input  logic [ASIZE-1:0] dst_addr,
  input  logic             rs_used,
  input  logic             rt_used,
  input  logic             dst_used,
  output logic             raw_stall,
  output logic             starve_stall,
  output logic             rf_wen,
  output logic [ASIZE-1:0] rf_waddr,
  output logic [DSIZE-1:0] rf_wdata,
  output logic [NREG-1:0]  sb_busy,
  output logic             sb_err
);

  localparam int                 AGE_W   = (MAXWAIT > 1) ? $clog2(MAXWAIT) : 1;
  localparam logic [AGE_W-1:0]   AGE_MAX = AGE_W'(MAXWAIT - 1);

  wb_entry_t        head;
  wb_entry_t        push_data;
  logic             full;
  logic             empty;
  logic             fifo_gnt;
  gnt_t             gnt;
  logic [AGE_W-1:0] age;
  logic             age_hit;
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_m;
  logic [NREG-1:0]  clr_mask;
  logic [NREG-1:0]  set_mask;
  logic             err_hit;

  // Readiness comes from registered occupancy only and is held low in reset.
  assign l_ready   = rst && !full;
  assign push_data = '{waddr: l_waddr, wdata: l_wdata};

  rf_wb_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (l_valid && l_ready),
    .push_data (push_data),
    .pop       (fifo_gnt),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Port grant: a pending freeze hands the port to the FIFO head, otherwise the pipeline wins.
  always_comb begin
    gnt      = GNT_NONE;
    rf_wen   = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (rst) begin
      if (starve_stall && !empty) gnt = GNT_FIFO;
      else if (p_wen)             gnt = GNT_PIPE;
      else if (!empty)            gnt = GNT_FIFO;
    end
    case (gnt)
      GNT_PIPE: begin
        rf_wen   = 1'b1;
        rf_waddr = p_waddr;
        rf_wdata = p_wdata;
      end
      GNT_FIFO: begin
        rf_wen   = 1'b1;
        rf_waddr = head.waddr;
        rf_wdata = head.wdata;
      end
      default: ;
    endcase
  end

  assign fifo_gnt = (gnt == GNT_FIFO);

  // The register written by the FIFO this cycle is forwarded by the register file,
  // so it no longer counts as a hazard for decode.
  assign clr_mask  = fifo_gnt  ? addr_onehot(head.waddr) : '0;
  assign set_mask  = iss_valid ? addr_onehot(iss_waddr)  : '0;
  assign busy_m    = busy & ~clr_mask;
  assign raw_stall = (rs_used  && busy_m[rs_addr])
                  || (rt_used  && busy_m[rt_addr])
                  || (dst_used && busy_m[dst_addr]);
  assign err_hit   = iss_valid && busy_m[iss_waddr];
  assign sb_busy   = busy;

  // Scoreboard: issue sets, FIFO write clears, set wins on a collision; error is sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy   <= '0;
      sb_err <= 1'b0;
    end else begin
      busy   <= busy_m | set_mask;
      sb_err <= sb_err | err_hit;
    end
  end

  // Freeze fires on the edge where the head's age would reach MAXWAIT-1 ungranted.
  assign age_hit = (int'(age) + 1 >= MAXWAIT - 1);

  // Head age tracking and the one-cycle starvation freeze.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      age          <= '0;
      starve_stall <= 1'b0;
    end else begin
      if (empty || fifo_gnt)  age <= '0;
      else if (age != AGE_MAX) age <= age + 1'b1;
      starve_stall <= !empty && !fifo_gnt && age_hit;
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter. Expected register-file writes are queued
// by the stimulus in the order they must appear; a monitor pops and compares on
// every cycle the DUT asserts rf_wen. Control outputs are checked inline.
module tb_rf_wport_arbiter;
  import rf_wport_arbiter_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             p_wen;
  logic [ASIZE-1:0] p_waddr;
  logic [DSIZE-1:0] p_wdata;
  logic             l_valid;
  logic [ASIZE-1:0] l_waddr;
  logic [DSIZE-1:0] l_wdata;
  logic             l_ready;
  logic             iss_valid;
  logic [ASIZE-1:0] iss_waddr;
  logic [ASIZE-1:0] rs_addr, rt_addr, dst_addr;
  logic             rs_used, rt_used, dst_used;
  logic             raw_stall;
  logic             starve_stall;
  logic             rf_wen;
  logic [ASIZE-1:0] rf_waddr;
  logic [DSIZE-1:0] rf_wdata;
  logic [NREG-1:0]  sb_busy;
  logic             sb_err;

  int tests = 0;
  int fails = 0;
  logic [ASIZE+DSIZE-1:0] exp_q[$];

  rf_wport_arbiter #(.MAXWAIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .p_wen        (p_wen),
    .p_waddr      (p_waddr),
    .p_wdata      (p_wdata),
    .l_valid      (l_valid),
    .l_waddr      (l_waddr),
    .l_wdata      (l_wdata),
    .l_ready      (l_ready),
    .iss_valid    (iss_valid),
    .iss_waddr    (iss_waddr),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .dst_addr     (dst_addr),
    .rs_used      (rs_used),
    .rt_used      (rt_used),
    .dst_used     (dst_used),
    .raw_stall    (raw_stall),
    .starve_stall (starve_stall),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .sb_busy      (sb_busy),
    .sb_err       (sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic idle();
    p_wen = 1'b0; p_waddr = '0; p_wdata = '0;
    l_valid = 1'b0; l_waddr = '0; l_wdata = '0;
    iss_valid = 1'b0; iss_waddr = '0;
    rs_addr = '0; rt_addr = '0; dst_addr = '0;
    rs_used = 1'b0; rt_used = 1'b0; dst_used = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of pipeline + long-latency stimulus with expected freeze/ready.
  task automatic cyc(input string tag,
                     input logic pw, input logic [DSIZE-1:0] pd,
                     input logic lv, input logic [ASIZE-1:0] la, input logic [DSIZE-1:0] ld,
                     input logic est, input logic elr);
    p_wen = pw; p_waddr = 4'd1; p_wdata = pd;
    l_valid = lv; l_waddr = la; l_wdata = ld;
    @(negedge clk);
    chk({tag, "_starve"}, {31'd0, starve_stall}, {31'd0, est});
    chk({tag, "_lready"}, {31'd0, l_ready}, {31'd0, elr});
    tick();
  endtask

  // Monitor: every write the DUT presents must match the next queued expectation.
  always @(negedge clk) begin
    if (rf_wen !== 1'b0) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got wen=%b addr=%0d data=0x%h, required no write",
                 rf_wen, rf_waddr, rf_wdata);
      end else begin
        chk("rf_write", {12'd0, rf_waddr, rf_wdata}, {12'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rf_wen",  {31'd0, rf_wen},       32'd0);
    chk("rst_l_ready", {31'd0, l_ready},      32'd0);
    chk("rst_starve",  {31'd0, starve_stall}, 32'd0);
    chk("rst_sb_err",  {31'd0, sb_err},       32'd0);
    chk("rst_sb_busy", {16'd0, sb_busy},      32'd0);
    tick();
    rst = 1'b1;

    // 1: zero-latency pipeline write
    p_wen = 1'b1; p_waddr = 4'd3; p_wdata = 16'h0042;
    exp_q.push_back({4'd3, 16'h0042});
    @(negedge clk);
    chk("t1_rf_wen",  {31'd0, rf_wen},       32'd1);
    chk("t1_raw",     {31'd0, raw_stall},    32'd0);
    chk("t1_starve",  {31'd0, starve_stall}, 32'd0);
    chk("t1_l_ready", {31'd0, l_ready},      32'd1);
    tick();
    idle();

    // 2: issue marks busy, decode stalls, result clears busy with forwarding
    iss_valid = 1'b1; iss_waddr = 4'd5;
    tick();
    iss_valid = 1'b0; rs_addr = 4'd5; rs_used = 1'b1;
    @(negedge clk);
    chk("t2_busy5", {31'd0, sb_busy[5]}, 32'd1);
    chk("t2_raw",   {31'd0, raw_stall},  32'd1);
    tick();
    l_valid = 1'b1; l_waddr = 4'd5; l_wdata = 16'h1234;
    exp_q.push_back({4'd5, 16'h1234});
    @(negedge clk);
    chk("t2_raw_wait", {31'd0, raw_stall}, 32'd1);
    chk("t2_no_write", {31'd0, rf_wen},    32'd0);
    tick();
    l_valid = 1'b0;
    @(negedge clk);
    chk("t2_rf_wen",  {31'd0, rf_wen},    32'd1);
    chk("t2_raw_fwd", {31'd0, raw_stall}, 32'd0);
    tick();
    idle();
    @(negedge clk);
    chk("t2_busy5_clr", {31'd0, sb_busy[5]}, 32'd0);
    tick();

    // 3: continuous pipeline traffic starves one buffered result
    exp_q.push_back({4'd1, 16'h0100});
    exp_q.push_back({4'd1, 16'h0101});
    exp_q.push_back({4'd1, 16'h0102});
    exp_q.push_back({4'd1, 16'h0103});
    exp_q.push_back({4'd7, 16'h0777});
    exp_q.push_back({4'd1, 16'h0104});
    cyc("t3_c0", 1'b1, 16'h0100, 1'b1, 4'd7, 16'h0777, 1'b0, 1'b1);
    cyc("t3_c1", 1'b1, 16'h0101, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);
    cyc("t3_c2", 1'b1, 16'h0102, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);
    cyc("t3_c3", 1'b1, 16'h0103, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);
    cyc("t3_c4", 1'b1, 16'h0104, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1);
    cyc("t3_c5", 1'b1, 16'h0104, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);
    idle();
    tick();

    // 4: three back-to-back results; FIFO fills, drains in order via freezes
    exp_q.push_back({4'd1,  16'h0200});
    exp_q.push_back({4'd1,  16'h0201});
    exp_q.push_back({4'd1,  16'h0202});
    exp_q.push_back({4'd1,  16'h0203});
    exp_q.push_back({4'd8,  16'h0801});
    exp_q.push_back({4'd1,  16'h0204});
    exp_q.push_back({4'd1,  16'h0205});
    exp_q.push_back({4'd1,  16'h0206});
    exp_q.push_back({4'd9,  16'h0902});
    exp_q.push_back({4'd1,  16'h0207});
    exp_q.push_back({4'd10, 16'h0A03});
    cyc("t4_c0",  1'b1, 16'h0200, 1'b1, 4'd8,  16'h0801, 1'b0, 1'b1);
    cyc("t4_c1",  1'b1, 16'h0201, 1'b1, 4'd9,  16'h0902, 1'b0, 1'b1);
    cyc("t4_c2",  1'b1, 16'h0202, 1'b1, 4'd10, 16'h0A03, 1'b0, 1'b0);
    cyc("t4_c3",  1'b1, 16'h0203, 1'b1, 4'd10, 16'h0A03, 1'b0, 1'b0);
    cyc("t4_c4",  1'b1, 16'h0204, 1'b1, 4'd10, 16'h0A03, 1'b1, 1'b0);
    cyc("t4_c5",  1'b1, 16'h0204, 1'b1, 4'd10, 16'h0A03, 1'b0, 1'b1);
    cyc("t4_c6",  1'b1, 16'h0205, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0);
    cyc("t4_c7",  1'b1, 16'h0206, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0);
    cyc("t4_c8",  1'b1, 16'h0207, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0);
    cyc("t4_c9",  1'b1, 16'h0207, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b1);
    cyc("t4_c10", 1'b0, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    chk("t4_drained_wen",    {31'd0, rf_wen},  32'd0);
    chk("t4_drained_lready", {31'd0, l_ready}, 32'd1);
    tick();

    // 5: issue/clear collision keeps busy; re-issue while busy sets sticky error
    iss_valid = 1'b1; iss_waddr = 4'd6;
    tick();
    iss_valid = 1'b0; l_valid = 1'b1; l_waddr = 4'd6; l_wdata = 16'h0606;
    exp_q.push_back({4'd6, 16'h0606});
    tick();
    l_valid = 1'b0; iss_valid = 1'b1; iss_waddr = 4'd6; rs_addr = 4'd6; rs_used = 1'b1;
    @(negedge clk);
    chk("t5_rf_wen",  {31'd0, rf_wen},    32'd1);
    chk("t5_raw_fwd", {31'd0, raw_stall}, 32'd0);
    tick();
    iss_valid = 1'b0; rs_used = 1'b0;
    @(negedge clk);
    chk("t5_busy6",     {31'd0, sb_busy[6]}, 32'd1);
    chk("t5_err_clear", {31'd0, sb_err},     32'd0);
    tick();
    iss_valid = 1'b1; iss_waddr = 4'd6;
    tick();
    iss_valid = 1'b0;
    @(negedge clk);
    chk("t5_err_set", {31'd0, sb_err}, 32'd1);
    tick();
    l_valid = 1'b1; l_waddr = 4'd6; l_wdata = 16'h0660;
    exp_q.push_back({4'd6, 16'h0660});
    tick();
    l_valid = 1'b0;
    @(negedge clk);
    chk("t5_err_sticky", {31'd0, sb_err}, 32'd1);
    chk("t5_rf_wen2",    {31'd0, rf_wen}, 32'd1);
    tick();
    @(negedge clk);
    chk("t5_busy6_clr", {31'd0, sb_busy[6]}, 32'd0);
    tick();

    // 6: reset mid-operation discards buffered results
    iss_valid = 1'b1; iss_waddr = 4'd2;
    p_wen = 1'b1; p_waddr = 4'd1; p_wdata = 16'h0300;
    l_valid = 1'b1; l_waddr = 4'd11; l_wdata = 16'h0B01;
    exp_q.push_back({4'd1, 16'h0300});
    tick();
    iss_valid = 1'b0; p_wdata = 16'h0301;
    l_waddr = 4'd12; l_wdata = 16'h0C02;
    exp_q.push_back({4'd1, 16'h0301});
    tick();
    l_valid = 1'b0; p_wdata = 16'h0302;
    #1;
    chk("t6_full",  {31'd0, l_ready},    32'd0);
    chk("t6_busy2", {31'd0, sb_busy[2]}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_rst_wen",    {31'd0, rf_wen},  32'd0);
    chk("t6_rst_lready", {31'd0, l_ready}, 32'd0);
    @(negedge clk);
    chk("t6_rst_busy",   {16'd0, sb_busy},      32'd0);
    chk("t6_rst_err",    {31'd0, sb_err},       32'd0);
    chk("t6_rst_starve", {31'd0, starve_stall}, 32'd0);
    tick();
    idle();
    rst = 1'b1;
    rs_addr = 4'd2; rs_used = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_post_wen",    {31'd0, rf_wen},    32'd0);
      chk("t6_post_lready", {31'd0, l_ready},   32'd1);
      chk("t6_post_raw",    {31'd0, raw_stall}, 32'd0);
      tick();
    end
    chk("t6_post_busy", {16'd0, sb_busy}, 32'd0);
    idle();

    chk("exp_queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
- Owns the single write port of the register file and shares it between two writers:
  - the pipeline writeback stage;
  - a long-latency unit (multiplier/divider/memory) that returns results out of order with the pipeline.
- Buffers long-latency results in a 2-entry FIFO and keeps a per-register busy scoreboard.
- Drives the hazard stall for decode and a starvation freeze for the pipeline.
- Sits between the WB stage, the long-latency unit, the decode hazard logic and the register file.

Parameters:
- DSIZE, 16, data width; shared constant, must equal the register file's.
- ASIZE, 4, register address width; shared constant.
- NREG, 16, number of registers; shared constant.
- MAXWAIT, 4, cycles a buffered result may wait before a freeze is forced; minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- p_wen  in  1  pipeline WB write request
- p_waddr  in  ASIZE  pipeline WB destination
- p_wdata  in  DSIZE  pipeline WB data
- l_valid  in  1  long-latency result valid
- l_waddr  in  ASIZE  long-latency destination
- l_wdata  in  DSIZE  long-latency data
- l_ready  out  1  FIFO can accept a result
- iss_valid  in  1  long-latency op issued; marks its destination busy
- iss_waddr  in  ASIZE  destination of the issued op
- rs_addr, rt_addr, dst_addr  in  ASIZE each  decode source and destination registers
- rs_used, rt_used, dst_used  in  1 each  qualifiers for the three decode addresses
- raw_stall  out  1  decode must stall
- starve_stall  out  1  pipeline must freeze this cycle
- rf_wen  out  1  to register file wen
- rf_waddr  out  ASIZE  to register file waddr
- rf_wdata  out  DSIZE  to register file wdata
- sb_busy  out  NREG  scoreboard bits, observation only
- sb_err  out  1  sticky error flag

Behaviour:
Reset (rst low, asynchronous):
- FIFO is emptied, busy is cleared, the age counter is set to 0.
- starve_stall=0, sb_err=0.
- rf_wen=0 and l_ready=0 are forced combinationally while rst is low.
- Asserting reset mid-operation drops any buffered results without writing them.

FIFO:
- 2 entries; each entry holds {waddr, wdata}.
- l_ready = !full, driven from registered state only.
- An entry is pushed on l_valid && l_ready at the clock edge.
- Minimum latency from handshake to rf_wen is 1 cycle.
- Push and pop may occur in the same cycle when full; the pop frees the slot at the same edge, but l_ready still reads 0 in that cycle.

Grant (combinational, zero latency for the pipeline):
- If starve_stall=1 and the FIFO is non-empty: grant the FIFO head. p_wen is ignored; the frozen pipeline re-presents it next cycle.
- Else if p_wen=1: grant the pipeline.
- Else if the FIFO is non-empty: grant the FIFO head.
- Else: rf_wen=0.
- rf_waddr/rf_wdata come from the granted source. When rf_wen=0 they are don't-care but held at 0.
- A FIFO grant pops the head at the edge.

Starvation:
- age increments each cycle the FIFO is non-empty and the head is not granted.
- age resets to 0 on a head pop or when the FIFO is empty.
- starve_stall is registered: set to 1 on the edge where age reaches MAXWAIT-1 and the head is not granted.
- It lasts exactly 1 cycle: it clears on the next edge because that cycle pops the head.

Scoreboard:
- busy[iss_waddr] is set at the edge when iss_valid=1.
- busy[r] is cleared at the edge when a FIFO grant writes r.
- If set and clear hit the same register in the same cycle, set wins.
- If iss_valid=1 and busy[iss_waddr] is already 1 (not being cleared that cycle), sb_err is set and stays set until reset.
- Register 0 is ordinary; there is no hardwired-zero register.

Hazard:
- raw_stall = (rs_used && busy'[rs_addr]) || (rt_used && busy'[rt_addr]) || (dst_used && busy'[dst_addr]).
- busy' is busy with the current cycle's FIFO-grant address masked off, because the register file forwards wdata in that same cycle.
- The dst check prevents WAW hazards between the pipeline and long-latency writes.

Decomposition:
- DSIZE, ASIZE and NREG come from the shared constants header used by the register file.
- MAXWAIT is local.
- One sub-module: rf_wb_fifo, the 2-entry FIFO with push/pop/full/empty.
- The grant logic, scoreboard and age counter stay in the top level.

Test Plan:
1. Reset released, idle; p_wen=1, p_waddr=3, p_wdata=0x0042 -> same cycle: rf_wen=1, rf_waddr=3, rf_wdata=0x0042. No stall outputs.
2. iss_valid=1, iss_waddr=5; next cycle decode rs_addr=5, rs_used=1 -> raw_stall=1. Then l_valid with waddr=5, data=0x1234 and p_wen=0 -> rf_wen=1 one cycle after the handshake; raw_stall=0 in that same cycle; sb_busy[5]=0 afterwards.
3. p_wen=1 every cycle, one long-latency result (waddr=7) buffered, MAXWAIT=4 -> starve_stall=1 in the 4th cycle after the push. That cycle writes reg 7 and ignores p_wen. starve_stall returns to 0 the next cycle.
4. Three back-to-back l_valid with p_wen=1 continuously -> l_ready=0 after the 2nd push; the 3rd is held by the producer. Both entries are drained in FIFO order, each via a starvation freeze.
5. Same-cycle iss_valid to reg 6 while a FIFO grant writes reg 6 -> busy[6]=1 afterwards and sb_err=0. Issuing reg 6 again while it is busy -> sb_err=1 and it stays 1.
6. Two results buffered and busy[2]=1; rst driven low mid-cycle -> rf_wen=0 and l_ready=0 immediately. After release: FIFO empty, sb_busy=0, nothing written.
